// File: rtl/board_pkg.sv
// Shared definitions for the dark-chess board store: piece/colour codes,
// the per-colour piece list, the canonical layout, LFSR taps and FSM states.
package board_pkg;

    localparam logic [2:0] PIECE_NONE    = 3'd0;
    localparam logic [2:0] PIECE_SOLDIER = 3'd1;
    localparam logic [2:0] PIECE_CANNON  = 3'd2;
    localparam logic [2:0] PIECE_KNIGHT  = 3'd3;
    localparam logic [2:0] PIECE_ROOK    = 3'd4;
    localparam logic [2:0] PIECE_BISHOP  = 3'd5;
    localparam logic [2:0] PIECE_QUEEN   = 3'd6;
    localparam logic [2:0] PIECE_KING    = 3'd7;

    localparam logic COLOR_RED   = 1'b0;
    localparam logic COLOR_BLACK = 1'b1;
    localparam logic COVERED     = 1'b0;
    localparam logic UNCOVERED   = 1'b1;

    // Pieces per colour indexed by type: entry t lives at bits [4t+3:4t].
    localparam logic [31:0] PIECE_COUNTS = {4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd5, 4'd0};

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        S_FILL    = 2'd0,
        S_SHUFFLE = 2'd1,
        S_READY   = 2'd2
    } state_t;

    // Walks KING down to SOLDIER so each colour lands in list order.
    function automatic logic [159:0] build_layout();
        logic [159:0] v;
        int idx;
        v   = '0;
        idx = 0;
        for (int c = 0; c < 2; c++) begin
            for (int t = 7; t >= 1; t--) begin
                for (int n = 0; n < int'(PIECE_COUNTS[4*t +: 4]); n++) begin
                    v[5*idx +: 5] = {c[0], t[2:0], COVERED};
                    idx++;
                end
            end
        end
        return v;
    endfunction

    localparam logic [159:0] CANON_LAYOUT = build_layout();

endpackage

// File: rtl/board_lfsr.sv
// 16-bit Galois LFSR feeding the shuffle; exposes its low five bits.
module board_lfsr
    import board_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en,
    output logic [4:0] o_rnd
);

    logic [15:0] r_lfsr;

    // Right-shifting Galois step; a nonzero seed never reaches zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lfsr <= SEED;
        end else if (i_en) begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'd0);
        end else begin
            r_lfsr <= r_lfsr;
        end
    end

    assign o_rnd = r_lfsr[4:0];

endmodule

// File: rtl/board_store.sv
// Board storage/setup engine for the 4x8 dark-chess board.
// Define BOARD_SHUFFLE_EN to shuffle the set after each fill.
module board_store
    import board_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED        = 16'hACE1,
    parameter int          PIECES_PER_COLOR = 16
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         new_game,
    input  logic         board_change_en,
    input  logic [4:0]   board_in_addr,
    input  logic [4:0]   board_in_piece,
    output logic [159:0] board_output,
    output logic         board_ready,
    output logic [4:0]   red_remaining,
    output logic [4:0]   black_remaining,
    output logic         game_over,
    output logic         winner,
    output logic         write_dropped
);

    state_t     r_state;
    state_t     w_state_seq;
    state_t     w_state_nxt;
    logic [4:0] r_board [32];
    logic [4:0] r_red;
    logic [4:0] r_black;
    logic       r_go;
    logic       r_winner;
    logic       r_ready;
    logic       r_wdrop;
    logic       w_wr_ok;
    logic       w_drop;
    logic [2:0] w_old_type;
    logic       w_old_color;
    logic       w_capture;

`ifdef BOARD_SHUFFLE_EN
    logic [4:0] r_idx;
    logic [4:0] w_rnd;
    logic [9:0] w_prod;
    logic [4:0] w_j;

    board_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .i_clk   (CLK),
        .i_reset (RESET),
        .i_en    (1'b1),
        .o_rnd   (w_rnd)
    );

    // j = floor(r*(i+1)/32) is always within 0..i.
    assign w_prod = 10'(w_rnd) * (10'(r_idx) + 10'd1);
    assign w_j    = w_prod[9:5];
`endif

    assign w_wr_ok     = board_change_en && !new_game && (r_state == S_READY);
    assign w_drop      = board_change_en && !w_wr_ok;
    assign w_old_type  = r_board[board_in_addr][3:1];
    assign w_old_color = r_board[board_in_addr][4];
    assign w_capture   = (w_old_type != PIECE_NONE) && (board_in_piece[3:1] != PIECE_NONE)
                         && (w_old_color != board_in_piece[4]);

    // Sequencing of fill, shuffle and ready; new_game overrides everything.
    always_comb begin
        w_state_seq = r_state;
        case (r_state)
`ifdef BOARD_SHUFFLE_EN
            S_FILL:    w_state_seq = S_SHUFFLE;
            S_SHUFFLE: begin
                if (r_idx == 5'd1) begin
                    w_state_seq = S_READY;
                end else begin
                    w_state_seq = S_SHUFFLE;
                end
            end
`else
            S_FILL:    w_state_seq = S_READY;
`endif
            S_READY:   w_state_seq = S_READY;
            default:   w_state_seq = S_FILL;
        endcase
        w_state_nxt = new_game ? S_FILL : w_state_seq;
    end

    // Board contents, piece counts and end-of-game tracking.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int k = 0; k < 32; k++) begin
                r_board[k] <= 5'd0;
            end
            r_state  <= S_FILL;
            r_red    <= 5'd0;
            r_black  <= 5'd0;
            r_go     <= 1'b0;
            r_winner <= 1'b0;
            r_ready  <= 1'b0;
            r_wdrop  <= 1'b0;
`ifdef BOARD_SHUFFLE_EN
            r_idx    <= 5'd31;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == S_READY);
            r_wdrop <= w_drop;
            case (r_state)
                S_FILL: begin
                    for (int k = 0; k < 32; k++) begin
                        r_board[k] <= CANON_LAYOUT[5*k +: 5];
                    end
                    r_red    <= 5'(PIECES_PER_COLOR);
                    r_black  <= 5'(PIECES_PER_COLOR);
                    r_go     <= 1'b0;
                    r_winner <= 1'b0;
`ifdef BOARD_SHUFFLE_EN
                    r_idx    <= 5'd31;
`endif
                end
`ifdef BOARD_SHUFFLE_EN
                S_SHUFFLE: begin
                    r_board[r_idx] <= r_board[w_j];
                    r_board[w_j]   <= r_board[r_idx];
                    r_idx          <= r_idx - 5'd1;
                end
`endif
                S_READY: begin
                    if (w_wr_ok) begin
                        r_board[board_in_addr] <= board_in_piece;
                        // The first colour to run out decides the winner.
                        if (w_capture && (w_old_color == COLOR_RED)) begin
                            if (r_red != 5'd0) r_red <= r_red - 5'd1;
                            if ((r_red <= 5'd1) && !r_go) begin
                                r_go     <= 1'b1;
                                r_winner <= COLOR_BLACK;
                            end
                        end else if (w_capture) begin
                            if (r_black != 5'd0) r_black <= r_black - 5'd1;
                            if ((r_black <= 5'd1) && !r_go) begin
                                r_go     <= 1'b1;
                                r_winner <= COLOR_RED;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < 32; k++) begin : g_flat
        assign board_output[5*k +: 5] = r_board[k];
    end

    assign board_ready     = r_ready;
    assign red_remaining   = r_red;
    assign black_remaining = r_black;
    assign game_over       = r_go;
    assign winner          = r_winner;
    assign write_dropped   = r_wdrop;

endmodule

// File: tb/tb_board_store.sv
// Scoreboard bench for board_store: stimulus queues expected values tagged
// with the cycle they must appear in, a negedge monitor compares them.
module tb_board_store;

`ifdef BOARD_SHUFFLE_EN
    localparam int LAT = 32;
`else
    localparam int LAT = 1;
`endif
    localparam int F_READY = 0, F_RED = 1, F_BLACK = 2, F_GO = 3, F_WIN = 4, F_DROP = 5;
    localparam int F_RKING = 8, F_BKING = 9, F_RSOL = 10, F_BSOL = 11, F_UNCOV = 12, F_SQ = 16;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         new_game = 1'b0;
    logic         board_change_en = 1'b0;
    logic [4:0]   board_in_addr = 5'd0;
    logic [4:0]   board_in_piece = 5'd0;
    logic [159:0] board_output;
    logic         board_ready;
    logic [4:0]   red_remaining;
    logic [4:0]   black_remaining;
    logic         game_over;
    logic         winner;
    logic         write_dropped;

    board_store dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .new_game        (new_game),
        .board_change_en (board_change_en),
        .board_in_addr   (board_in_addr),
        .board_in_piece  (board_in_piece),
        .board_output    (board_output),
        .board_ready     (board_ready),
        .red_remaining   (red_remaining),
        .black_remaining (black_remaining),
        .game_over       (game_over),
        .winner          (winner),
        .write_dropped   (write_dropped)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] count_code(input logic [4:0] code);
        logic [31:0] n;
        n = 32'd0;
        for (int k = 0; k < 32; k++) begin
            if (board_output[5*k +: 5] == code) n = n + 32'd1;
        end
        return n;
    endfunction

    function automatic logic [31:0] field(input int sel);
        logic [31:0] n;
        n = 32'd0;
        case (sel)
            F_READY: return {31'd0, board_ready};
            F_RED:   return {27'd0, red_remaining};
            F_BLACK: return {27'd0, black_remaining};
            F_GO:    return {31'd0, game_over};
            F_WIN:   return {31'd0, winner};
            F_DROP:  return {31'd0, write_dropped};
            F_RKING: return count_code(5'b01110);
            F_BKING: return count_code(5'b11110);
            F_RSOL:  return count_code(5'b00010);
            F_BSOL:  return count_code(5'b10010);
            F_UNCOV: begin
                for (int k = 0; k < 32; k++) n = n + {31'd0, board_output[5*k]};
                return n;
            end
            default: return {27'd0, board_output[5*(sel-F_SQ) +: 5]};
        endcase
    endfunction

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge CLK) begin
        int k;
        logic [31:0] act;
        k = 0;
        while (k < sb_q.size()) begin
            if (sb_q[k].cyc == cyc) begin
                act = field(sb_q[k].sel);
                n_cmp++;
                if (act !== sb_q[k].exp) begin
                    n_err++;
                    $display("FAIL %s (cycle %0d): got %0d, need %0d",
                             sb_q[k].name, cyc, act, sb_q[k].exp);
                end
                sb_q.delete(k);
            end else begin
                k++;
            end
        end
    end

    task automatic expect_at(input int dly, input int sel, input logic [31:0] exp, input string name);
        exp_t e;
        e.cyc  = cyc + dly;
        e.sel  = sel;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic wr(input logic [4:0] a, input logic [4:0] p);
        board_change_en = 1'b1;
        board_in_addr   = a;
        board_in_piece  = p;
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_setup(input string tag);
        expect_at(0, F_RED, 32'd16, {tag, "_red"});
        expect_at(0, F_BLACK, 32'd16, {tag, "_black"});
        expect_at(0, F_GO, 32'd0, {tag, "_game_over"});
`ifdef BOARD_SHUFFLE_EN
        expect_at(0, F_RKING, 32'd1, {tag, "_red_kings"});
        expect_at(0, F_BKING, 32'd1, {tag, "_black_kings"});
        expect_at(0, F_RSOL, 32'd5, {tag, "_red_soldiers"});
        expect_at(0, F_BSOL, 32'd5, {tag, "_black_soldiers"});
        expect_at(0, F_UNCOV, 32'd0, {tag, "_uncovered"});
`else
        expect_at(0, F_SQ + 0, 32'd14, {tag, "_sq0"});
        expect_at(0, F_SQ + 4, 32'd10, {tag, "_sq4"});
        expect_at(0, F_SQ + 5, 32'd8, {tag, "_sq5"});
        expect_at(0, F_SQ + 16, 32'd30, {tag, "_sq16"});
        expect_at(0, F_SQ + 31, 32'd18, {tag, "_sq31"});
`endif
    endtask

    initial begin
        int c;
        int sq;
        repeat (3) @(posedge CLK);
        #1;
        expect_at(0, F_READY, 32'd0, "rst_ready");
        expect_at(0, F_RED, 32'd0, "rst_red");
        expect_at(0, F_BLACK, 32'd0, "rst_black");
        expect_at(0, F_GO, 32'd0, "rst_game_over");
        expect_at(0, F_DROP, 32'd0, "rst_dropped");
        expect_at(0, F_SQ + 0, 32'd0, "rst_sq0");
        expect_at(0, F_SQ + 31, 32'd0, "rst_sq31");
        RESET = 1'b0;
        expect_at(LAT - 1, F_READY, 32'd0, "ready_early");
        expect_at(LAT, F_READY, 32'd1, "ready_rise");
        repeat (LAT) @(posedge CLK);
        #1;
        expect_setup("init");
        n_cmp++;
        if (board_ready !== 1'b1) begin
            n_err++;
            $display("FAIL init_ready_direct: got %0d, need 1", board_ready);
        end

        // Erase, drop a black soldier on the hole, capture it with red.
        wr(5'd5, 5'b00000);
        wr(5'd5, 5'b10011);
        expect_at(1, F_BLACK, 32'd15, "first_capture_black");
        expect_at(1, F_RED, 32'd16, "first_capture_red");
        expect_at(1, F_SQ + 5, 32'd15, "first_capture_sq5");
        wr(5'd5, 5'b01111);
        expect_at(1, F_BLACK, 32'd15, "erase_black");
        expect_at(1, F_RED, 32'd16, "erase_red");
        expect_at(1, F_SQ + 4, 32'd0, "erase_sq4");
        wr(5'd4, 5'b00000);

        // Fifteen more captures, each back to back on one square.
        for (int n = 0; n < 15; n++) begin
            sq = 6 + n;
            wr(5'(sq), 5'b00000);
            wr(5'(sq), 5'b10011);
            expect_at(1, F_BLACK, 32'(14 - n), "capture_black");
            expect_at(1, F_GO, (n == 14) ? 32'd1 : 32'd0, "capture_game_over");
            wr(5'(sq), 5'b01111);
        end
        expect_at(0, F_WIN, 32'd0, "winner_red");
        expect_at(0, F_RED, 32'd16, "end_red");
        wr(5'd25, 5'b00000);
        wr(5'd25, 5'b10011);
        expect_at(1, F_BLACK, 32'd0, "saturate_black");
        expect_at(1, F_GO, 32'd1, "sticky_game_over");
        expect_at(1, F_SQ + 25, 32'd15, "after_over_write");
        wr(5'd25, 5'b01111);
        board_change_en = 1'b0;
        @(posedge CLK);
        #1;

        // new_game together with a write, then a strobe while filling.
        c = cyc;
        expect_at(1, F_DROP, 32'd1, "ng_write_dropped");
        expect_at(1, F_READY, 32'd0, "ng_ready_low");
        expect_at(1, F_RED, 32'd16, "ng_write_ignored");
        expect_at(2, F_DROP, 32'd1, "fill_write_dropped");
        expect_at(2, F_GO, 32'd0, "ng_game_over_cleared");
        expect_at(2, F_BLACK, 32'd16, "ng_black_reload");
        expect_at(3, F_DROP, 32'd0, "drop_one_pulse");
        expect_at(LAT, F_READY, 32'd0, "ng_ready_early");
        expect_at(LAT + 1, F_READY, 32'd1, "ng_ready_rise");
        new_game = 1'b1;
        wr(5'd0, 5'b10011);
        new_game = 1'b0;
        wr(5'd0, 5'b10011);
        board_change_en = 1'b0;
`ifdef BOARD_SHUFFLE_EN
        repeat (9) @(posedge CLK);
        #1;
        expect_at(1, F_DROP, 32'd1, "shuffle_write_dropped");
        expect_at(1, F_BLACK, 32'd16, "shuffle_black");
        expect_at(2, F_DROP, 32'd0, "shuffle_drop_pulse");
        wr(5'd3, 5'b10011);
        board_change_en = 1'b0;
`endif
        while (cyc < c + LAT + 1) begin
            @(posedge CLK);
            #1;
        end
        expect_setup("newgame");
        expect_at(1, F_SQ + 31, 32'd0, "post_ng_write");
        wr(5'd31, 5'b00000);
        board_change_en = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++;
        if (game_over !== 1'b0) begin
            n_err++;
            $display("FAIL final_game_over_direct: got %0d, need 0", game_over);
        end
        n_cmp++;
        if (black_remaining !== 5'd16) begin
            n_err++;
            $display("FAIL final_black_direct: got %0d, need 16", black_remaining);
        end
        foreach (sb_q[i]) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: never sampled, need %0d", sb_q[i].name, sb_q[i].exp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

endmodule
